mcp300x_responder: RTL and testbench

MCP300X_RESPONDER -- requirements
Module: mcp300x_responder

---
 rtl/mcp300x_pkg.sv | 28 ++
 rtl/mcp300x_sample_bank.sv | 50 +++++
 rtl/mcp300x_responder.sv | 130 +++++++++++++
 tb/tb_mcp300x_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp300x_pkg.sv
// Shared constants for the MCP3004/MCP3008 SPI ADC responder: state encoding,
// bit positions within a transfer and the single/differential command codes.
package mcp300x_pkg;

    localparam int DATA_W = 10;
    localparam int RISE_W = 5;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_CMD        = 3'd2;
    localparam logic [2:0] ST_DATA       = 3'd3;
    localparam logic [2:0] ST_TRAIL      = 3'd4;

    localparam logic [RISE_W-1:0] RISE_NULL = 5'd6;
    localparam logic [RISE_W-1:0] RISE_LAST = 5'd16;

    localparam logic CMD_READ_SINGLE       = 1'b1;
    localparam logic CMD_READ_DIFFERENTIAL = 1'b0;

    // Differential conversion never goes negative: pos - neg, floored at zero.
    function automatic logic [DATA_W-1:0] clamp_diff(input logic [DATA_W-1:0] pos,
                                                     input logic [DATA_W-1:0] neg);
        logic [DATA_W:0] d;
        d = {1'b0, pos} - {1'b0, neg};
        return d[DATA_W] ? '0 : d[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mcp300x_sample_bank.sv
// Eight-entry sample register file with a combinational single/differential
// result mux; entries at or above NUM_CH do not exist and read as zero.
module mcp300x_sample_bank
    import mcp300x_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic              clk_doubleSCLK,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_single,
    input  logic [2:0]        rd_ch,
    output logic [DATA_W-1:0] rd_result
);

    logic [DATA_W-1:0] bank_word [8];
    logic [2:0]        ch_neg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_entry
            if (gi < NUM_CH) begin : g_live
                logic [DATA_W-1:0] entry_reg;
                always_ff @(posedge clk_doubleSCLK or posedge reset) begin
                    if (reset)
                        entry_reg <= '0;
                    else if (wr_en && (wr_ch == 3'(gi)))
                        entry_reg <= wr_data;
                end
                assign bank_word[gi] = entry_reg;
            end else begin : g_absent
                assign bank_word[gi] = '0;
            end
        end
    endgenerate

    // The negative input of a differential pair is the channel's partner (D0 flipped).
    assign ch_neg = {rd_ch[2:1], ~rd_ch[0]};

    always_comb begin
        rd_result = '0;
        unique case (rd_single)
            CMD_READ_SINGLE:       rd_result = bank_word[rd_ch];
            CMD_READ_DIFFERENTIAL: rd_result = clamp_diff(bank_word[rd_ch], bank_word[ch_neg]);
            default:               rd_result = '0;
        endcase
    end

endmodule

// File: rtl/mcp300x_responder.sv
// SPI target emulating an MCP3004/MCP3008: decodes start/SGL/D2..D0 from the
// host and shifts back a null bit plus a 10-bit sample from the bank.
module mcp300x_responder
    import mcp300x_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic              clk_doubleSCLK,
    input  logic              reset,
    input  logic              SCLK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    output logic              cmd_valid,
    output logic              cmd_single,
    output logic [2:0]        cmd_channel,
    output logic              xfer_done,
    output logic              xfer_abort
);

    logic [2:0]        state_reg;
    logic              sclk_q;
    logic              rise;
    logic [RISE_W-1:0] rise_cnt_reg;
    logic [3:0]        cmd_sr_reg;
    logic [DATA_W-1:0] data_sr_reg;
    logic [DATA_W-1:0] bank_result;

    assign rise = SCLK & ~sclk_q;

    mcp300x_sample_bank #(
        .NUM_CH(NUM_CH)
    ) u_bank (
        .clk_doubleSCLK(clk_doubleSCLK),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_ch         (wr_ch),
        .wr_data       (wr_data),
        .rd_single     (cmd_sr_reg[3]),
        .rd_ch         (cmd_sr_reg[2:0]),
        .rd_result     (bank_result)
    );

    always_ff @(posedge clk_doubleSCLK or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            sclk_q       <= 1'b0;
            rise_cnt_reg <= '0;
            cmd_sr_reg   <= '0;
            data_sr_reg  <= '0;
            MISO         <= 1'b0;
            MISO_oe      <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_single   <= 1'b0;
            cmd_channel  <= '0;
            xfer_done    <= 1'b0;
            xfer_abort   <= 1'b0;
        end else begin
            sclk_q     <= SCLK;
            cmd_valid  <= 1'b0;
            xfer_done  <= 1'b0;
            xfer_abort <= 1'b0;
            if (CS) begin
                // Deselect wins over everything; classify how far the transfer got.
                case (state_reg)
                    ST_CMD:   xfer_abort <= 1'b1;
                    ST_DATA:  if (rise_cnt_reg == RISE_LAST) xfer_done <= 1'b1;
                              else                           xfer_abort <= 1'b1;
                    ST_TRAIL: xfer_done <= 1'b1;
                    default:  ;
                endcase
                state_reg    <= ST_IDLE;
                rise_cnt_reg <= '0;
                MISO         <= 1'b0;
                MISO_oe      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg    <= ST_WAIT_START;
                        rise_cnt_reg <= '0;
                    end
                    ST_WAIT_START: begin
                        if (rise && MOSI) begin
                            rise_cnt_reg <= 5'd1;
                            state_reg    <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (rise) begin
                            rise_cnt_reg <= rise_cnt_reg + 5'd1;
                            if (rise_cnt_reg == RISE_NULL - 5'd1) begin
                                data_sr_reg <= bank_result;
                                MISO        <= 1'b0;
                                MISO_oe     <= 1'b1;
                                cmd_valid   <= 1'b1;
                                cmd_single  <= cmd_sr_reg[3];
                                cmd_channel <= cmd_sr_reg[2:0];
                                state_reg   <= ST_DATA;
                            end else begin
                                cmd_sr_reg <= {cmd_sr_reg[2:0], MOSI};
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rise) begin
                            if (rise_cnt_reg == RISE_LAST) begin
                                MISO      <= 1'b0;
                                state_reg <= ST_TRAIL;
                            end else begin
                                MISO         <= data_sr_reg[DATA_W-1];
                                data_sr_reg  <= {data_sr_reg[DATA_W-2:0], 1'b0};
                                rise_cnt_reg <= rise_cnt_reg + 5'd1;
                            end
                        end
                    end
                    ST_TRAIL: begin
                        MISO    <= 1'b0;
                        MISO_oe <= 1'b1;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp300x_responder.sv
// Drives an 8-channel and a 4-channel responder with identical SPI traffic and
// checks decoded commands and captured result bits against a behavioural model.
`timescale 1ns/1ps
module tb_mcp300x_responder;

    logic       clk_doubleSCLK = 1'b0;
    logic       reset = 1'b1;
    logic       SCLK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = 3'd0;
    logic [9:0] wr_data = 10'd0;

    logic       miso8, oe8, cv8, single8, done8, abort8;
    logic [2:0] ch8;
    logic       miso4, oe4, cv4, single4, done4, abort4;
    logic [2:0] ch4;

    always #5 clk_doubleSCLK = ~clk_doubleSCLK;

    mcp300x_responder #(.NUM_CH(8)) dut8 (
        .clk_doubleSCLK(clk_doubleSCLK), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(miso8), .MISO_oe(oe8), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .cmd_valid(cv8), .cmd_single(single8), .cmd_channel(ch8),
        .xfer_done(done8), .xfer_abort(abort8)
    );

    mcp300x_responder #(.NUM_CH(4)) dut4 (
        .clk_doubleSCLK(clk_doubleSCLK), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(miso4), .MISO_oe(oe4), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .cmd_valid(cv4), .cmd_single(single4), .cmd_channel(ch4),
        .xfer_done(done4), .xfer_abort(abort4)
    );

    typedef struct {
        bit single;
        int ch;
        int res8;
        int res4;
        bit complete;
    } exp_t;

    exp_t exp_q[$];
    int   model_bank[8];
    int   n_vec = 0;
    int   n_err = 0;

    bit          mon_active = 1'b0;
    int          mon_nbits = 0;
    logic [10:0] cap8 = '0;
    logic [10:0] cap4 = '0;
    logic        sclk_prev = 1'b0;
    exp_t        cur;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, req);
        end
    endtask

    // Reference: an ADC that reads bank[ch], or the floored difference of a channel pair.
    function automatic int ref_result(input int num_ch, input bit single, input int ch);
        int a, b;
        a = (ch < num_ch) ? model_bank[ch] : 0;
        if (single) return a;
        b = ((ch ^ 1) < num_ch) ? model_bank[ch ^ 1] : 0;
        return (a > b) ? a - b : 0;
    endfunction

    task automatic tick();
        @(posedge clk_doubleSCLK);
        #1;
    endtask

    task automatic rise_bit(input logic mosi_bit, input bit do_wr,
                            input logic [2:0] wch, input logic [9:0] wd);
        SCLK = 1'b0;
        MOSI = mosi_bit;
        tick();
        repeat ($urandom_range(0, 1)) tick();
        SCLK    = 1'b1;
        wr_en   = do_wr;
        wr_ch   = wch;
        wr_data = wd;
        tick();
        wr_en = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic write_bank(input logic [2:0] ch, input logic [9:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model_bank[ch] = int'(d);
        $display("write ch%0d <= 0x%03h", ch, d);
    endtask

    task automatic check_reset_outputs();
        check("reset_outputs8", int'({miso8, oe8, cv8, single8, ch8, done8, abort8}), 0);
        check("reset_outputs4", int'({miso4, oe4, cv4, single4, ch4, done4, abort4}), 0);
    endtask

    // stop_at = 0 runs the transfer to completion; otherwise CS rises (or reset
    // hits, when rst_at_stop) right after that rise number.
    task automatic transfer(input bit single, input logic [2:0] ch, input int lead,
                            input int stop_at, input bit wr6, input logic [2:0] wch,
                            input logic [9:0] wd, input bit rst_at_stop);
        exp_t e;
        int   last;
        e.single   = single;
        e.ch       = int'(ch);
        e.res8     = ref_result(8, single, int'(ch));
        e.res4     = ref_result(4, single, int'(ch));
        e.complete = (stop_at == 0);
        exp_q.push_back(e);
        $display("xfer sgl=%0d ch=%0d lead=%0d stop=%0d wr6=%0d exp8=0x%03h exp4=0x%03h",
                 single, ch, lead, stop_at, wr6, e.res8, e.res4);
        last = 17 + int'($urandom_range(0, 2));
        CS = 1'b0;
        tick();
        tick();
        repeat (lead) rise_bit(1'b0, 1'b0, 3'd0, 10'd0);
        rise_bit(1'b1, 1'b0, 3'd0, 10'd0);
        rise_bit(single, 1'b0, 3'd0, 10'd0);
        for (int b = 2; b >= 0; b--) rise_bit(ch[b], 1'b0, 3'd0, 10'd0);
        rise_bit(1'($urandom_range(0, 1)), wr6, wch, wd);
        if (wr6) model_bank[wch] = int'(wd);
        for (int r = 7; r <= last; r++) begin
            rise_bit(1'b0, 1'b0, 3'd0, 10'd0);
            if (r == stop_at) break;
        end
        if (rst_at_stop) begin
            reset = 1'b1;
            #1;
            check_reset_outputs();
            SCLK = 1'b0;
            CS   = 1'b1;
            tick();
            reset = 1'b0;
            for (int i = 0; i < 8; i++) model_bank[i] = 0;
            tick();
        end else begin
            SCLK = 1'b0;
            tick();
            CS = 1'b1;
            tick();
            tick();
        end
    endtask

    // Monitor: pops an expectation on each decoded command, captures MISO at
    // every host SCLK rise, and judges the transfer when it ends.
    initial begin
        forever begin
            @(negedge clk_doubleSCLK);
            if (reset) begin
                mon_active = 1'b0;
                mon_nbits  = 0;
                sclk_prev  = SCLK;
                continue;
            end
            if (cv8 || cv4) begin
                check("cmd_valid_pair", int'({cv8, cv4}), 3);
                if (exp_q.size() == 0) begin
                    check("cmd_without_expect", int'({cv8, cv4}), 0);
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_nbits  = 0;
                    cap8       = '0;
                    cap4       = '0;
                    check("cmd_single8", int'(single8), int'(cur.single));
                    check("cmd_channel8", int'(ch8), cur.ch);
                    check("cmd_single4", int'(single4), int'(cur.single));
                    check("cmd_channel4", int'(ch4), cur.ch);
                end
            end
            if (mon_active && SCLK && !sclk_prev && mon_nbits < 11) begin
                cap8 = {cap8[9:0], miso8};
                cap4 = {cap4[9:0], miso4};
                mon_nbits++;
                if (!(oe8 && oe4)) check("miso_oe_driven", int'({oe8, oe4}), 3);
            end
            if (done8 || done4 || abort8 || abort4) begin
                if (!mon_active) begin
                    check("end_without_cmd", int'({done8, done4, abort8, abort4}), 0);
                end else begin
                    check("end_kind8", int'({done8, abort8}), cur.complete ? 2 : 1);
                    check("end_kind4", int'({done4, abort4}), cur.complete ? 2 : 1);
                    if (cur.complete) begin
                        check("bits_captured", mon_nbits, 11);
                        check("result8", int'(cap8), cur.res8);
                        check("result4", int'(cap4), cur.res4);
                        $display("done ch=%0d got8=0x%03h got4=0x%03h", cur.ch, cap8, cap4);
                    end else begin
                        check("abort_oe_low", int'({oe8, oe4}), 0);
                        $display("abort ch=%0d", cur.ch);
                    end
                    mon_active = 1'b0;
                end
            end
            sclk_prev = SCLK;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          sgl;
        logic [2:0]  ch;
        logic [2:0]  wch;
        logic [9:0]  wd;
        int          stop;
        bit          w6;
        for (int i = 0; i < 8; i++) model_bank[i] = 0;
        tick();
        tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();

        write_bank(3'd5, 10'h2A5);
        transfer(1'b1, 3'd5, 0, 0, 1'b0, 3'd0, 10'd0, 1'b0);
        write_bank(3'd0, 10'h001);
        transfer(1'b1, 3'd0, 2, 0, 1'b0, 3'd0, 10'd0, 1'b0);
        write_bank(3'd2, 10'h300);
        write_bank(3'd3, 10'h100);
        transfer(1'b0, 3'd2, 0, 0, 1'b0, 3'd0, 10'd0, 1'b0);
        transfer(1'b0, 3'd3, 1, 0, 1'b0, 3'd0, 10'd0, 1'b0);
        write_bank(3'd5, 10'h155);
        transfer(1'b1, 3'd5, 0, 0, 1'b1, 3'd5, 10'h3FF, 1'b0);
        transfer(1'b1, 3'd5, 0, 0, 1'b0, 3'd0, 10'd0, 1'b0);
        transfer(1'b1, 3'd2, 0, 9, 1'b0, 3'd0, 10'd0, 1'b0);
        transfer(1'b1, 3'd2, 0, 0, 1'b0, 3'd0, 10'd0, 1'b0);
        write_bank(3'd6, 10'h123);
        transfer(1'b1, 3'd6, 0, 0, 1'b0, 3'd0, 10'd0, 1'b0);
        transfer(1'b1, 3'd5, 0, 12, 1'b0, 3'd0, 10'd0, 1'b1);
        transfer(1'b1, 3'd5, 0, 0, 1'b0, 3'd0, 10'd0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) write_bank(3'($urandom_range(0, 7)), 10'($urandom));
            sgl  = 1'($urandom_range(0, 1));
            ch   = 3'($urandom_range(0, 7));
            stop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 15)) : 0;
            w6   = ($urandom_range(0, 6) == 0);
            wch  = 3'($urandom_range(0, 7));
            wd   = 10'($urandom);
            transfer(sgl, ch, int'($urandom_range(0, 3)), stop, w6, wch, wd, 1'b0);
        end

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
